// File: rtl/riscv_32m_muldiv_sequencer_pkg.sv
// Shared RV32M definitions for the multiply/divide sequencer.
// Contents: widths, RV32M func7/func3 encodings, FSM state encodings,
// the operand-conditioner payload struct and conditional-negate helpers.
// Optional feature macro used by the sequencer: RV32M_FAST_MUL_EN.
package riscv_32m_muldiv_sequencer_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned CNT_W  = 5;
   localparam int unsigned PROD_W = 2 * XLEN;

   localparam logic [6:0] RV32M_FUNC7 = 7'b0000001;

   localparam logic [2:0] RV32M_FUNC3_MUL    = 3'b000;
   localparam logic [2:0] RV32M_FUNC3_MULH   = 3'b001;
   localparam logic [2:0] RV32M_FUNC3_MULHSU = 3'b010;
   localparam logic [2:0] RV32M_FUNC3_MULHU  = 3'b011;
   localparam logic [2:0] RV32M_FUNC3_DIV    = 3'b100;
   localparam logic [2:0] RV32M_FUNC3_DIVU   = 3'b101;
   localparam logic [2:0] RV32M_FUNC3_REM    = 3'b110;
   localparam logic [2:0] RV32M_FUNC3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      MULDIV_STATE_IDLE = 2'd0,
      MULDIV_STATE_MUL  = 2'd1,
      MULDIV_STATE_DIV  = 2'd2,
      MULDIV_STATE_FIX  = 2'd3
   } muldiv_state_e;

   // Magnitudes and sign flags of both operands as seen by the selected op.
   typedef struct packed {
      logic [XLEN-1:0] abs_a;
      logic [XLEN-1:0] abs_b;
      logic            neg_a;
      logic            neg_b;
   } operand_cond_t;

   function automatic logic [XLEN-1:0] neg_if32(input logic [XLEN-1:0] v, input logic n);
      return n ? XLEN'(-v) : v;
   endfunction

   function automatic logic [PROD_W-1:0] neg_if64(input logic [PROD_W-1:0] v, input logic n);
      return n ? PROD_W'(-v) : v;
   endfunction

endpackage

// File: rtl/riscv_32m_muldiv_sequencer_operand_conditioner.sv
// Combinational operand conditioner for RV32M ops.
// Ports:
//   func3_i : RV32M op select (decides which operands are signed)
//   in0_i   : rs1 operand
//   in1_i   : rs2 operand
//   cond_o  : magnitudes and sign flags of both operands
module riscv_32m_muldiv_sequencer_operand_conditioner
   import riscv_32m_muldiv_sequencer_pkg::*;
(
   input  logic [2:0]      func3_i,
   input  logic [XLEN-1:0] in0_i,
   input  logic [XLEN-1:0] in1_i,
   output operand_cond_t   cond_o
);

   logic signed_a;
   logic signed_b;
   logic neg_a;
   logic neg_b;

   // Signedness of rs1/rs2 per op; MULHSU treats only rs1 as signed.
   always_comb begin
      signed_a = 1'b0;
      signed_b = 1'b0;
      case (func3_i)
         RV32M_FUNC3_MUL,
         RV32M_FUNC3_MULH,
         RV32M_FUNC3_DIV,
         RV32M_FUNC3_REM: begin
            signed_a = 1'b1;
            signed_b = 1'b1;
         end
         RV32M_FUNC3_MULHSU: signed_a = 1'b1;
         default: ;
      endcase
   end

   assign neg_a = signed_a & in0_i[XLEN-1];
   assign neg_b = signed_b & in1_i[XLEN-1];

   assign cond_o.neg_a = neg_a;
   assign cond_o.neg_b = neg_b;
   assign cond_o.abs_a = neg_if32(in0_i, neg_a);
   assign cond_o.abs_b = neg_if32(in1_i, neg_b);

endmodule

// File: rtl/riscv_32m_muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer running beside the 32I ALU.
// Iterative shift-add multiply and restoring divide on magnitudes, with a
// single sign fix-up cycle before the result is registered.
// Optional macro RV32M_FAST_MUL_EN: multiply ops use a single-cycle product
// computed on the accept edge and go straight to the fix-up cycle.
// Ports:
//   clock_i  : core clock, rising edge
//   reset_i  : asynchronous active-high reset
//   req_i    : start request, sampled only while idle
//   func3_i  : RV32M op select, captured on accept
//   in0_i    : rs1 operand, captured on accept
//   in1_i    : rs2 operand, captured on accept
//   flush_i  : abort any operation in flight (no done, result untouched)
//   busy_o   : high while an accepted op is in progress
//   done_o   : one-cycle pulse, out_o valid in this cycle
//   out_o    : result, held until the next done_o
module riscv_32m_muldiv_sequencer
   import riscv_32m_muldiv_sequencer_pkg::*;
(
   input  logic            clock_i,
   input  logic            reset_i,
   input  logic            req_i,
   input  logic [2:0]      func3_i,
   input  logic [XLEN-1:0] in0_i,
   input  logic [XLEN-1:0] in1_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] out_o
);

   muldiv_state_e     state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        func3_q, func3_d;
   // Multiplicand for MUL, divisor for DIV.
   logic [XLEN-1:0]   opnd_q, opnd_d;
   // MUL: {partial product, remaining multiplier bits}; DIV: {remainder, quotient}.
   logic [PROD_W-1:0] acc_q, acc_d;
   logic              neg_a_q, neg_a_d;
   logic              neg_b_q, neg_b_d;
   // Result in acc is already final (special cases, fast multiply).
   logic              nofix_q, nofix_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [XLEN-1:0]   out_q, out_d;

   operand_cond_t     cond;
   logic              div_by_zero;
   logic              div_overflow;

   riscv_32m_muldiv_sequencer_operand_conditioner u_cond (
      .func3_i (func3_i),
      .in0_i   (in0_i),
      .in1_i   (in1_i),
      .cond_o  (cond)
   );

   assign div_by_zero  = (in1_i == '0);
   assign div_overflow = ((func3_i == RV32M_FUNC3_DIV) || (func3_i == RV32M_FUNC3_REM)) &&
                         (in0_i == {1'b1, {(XLEN-1){1'b0}}}) && (in1_i == '1);

`ifdef RV32M_FAST_MUL_EN
   // 33x33 signed product; modulo 2^64 it equals the 64-bit product of the
   // sign/zero-extended operands.
   logic              fast_sa;
   logic              fast_sb;
   logic [PROD_W-1:0] fast_a;
   logic [PROD_W-1:0] fast_b;
   logic [PROD_W-1:0] fast_prod;

   assign fast_sa   = (func3_i != RV32M_FUNC3_MULHU);
   assign fast_sb   = ~func3_i[1];
   assign fast_a    = {{XLEN{fast_sa & in0_i[XLEN-1]}}, in0_i};
   assign fast_b    = {{XLEN{fast_sb & in1_i[XLEN-1]}}, in1_i};
   assign fast_prod = PROD_W'(fast_a * fast_b);
`endif

   // Shift-add step: add multiplicand to the upper half when the current
   // multiplier LSB is set, then shift the whole accumulator right.
   logic [XLEN:0]     mul_sum;
   logic [PROD_W-1:0] mul_next;

   assign mul_sum  = {1'b0, acc_q[PROD_W-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

   // Restoring step: shift the next dividend bit into the remainder and
   // keep the difference only if it did not go negative.
   logic [XLEN:0]     div_shift;
   logic              div_ge;
   logic [XLEN-1:0]   div_sub;
   logic [PROD_W-1:0] div_next;

   assign div_shift = {acc_q[PROD_W-1:XLEN], acc_q[XLEN-1]};
   assign div_ge    = (div_shift >= {1'b0, opnd_q});
   assign div_sub   = div_shift[XLEN-1:0] - opnd_q;
   assign div_next  = {(div_ge ? div_sub : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};

   // Sign fix-up values used in the FIX cycle.
   logic              fix_neg_q;
   logic [PROD_W-1:0] fix_prod;
   logic [XLEN-1:0]   fix_quot;
   logic [XLEN-1:0]   fix_rem;
   logic [XLEN-1:0]   fix_out;

   assign fix_neg_q = ~nofix_q & (neg_a_q ^ neg_b_q);
   assign fix_prod  = neg_if64(acc_q, fix_neg_q);
   assign fix_quot  = neg_if32(acc_q[XLEN-1:0], fix_neg_q);
   assign fix_rem   = neg_if32(acc_q[PROD_W-1:XLEN], ~nofix_q & neg_a_q);

   always_comb begin
      fix_out = '0;
      case (func3_q)
         RV32M_FUNC3_MUL:                     fix_out = fix_prod[XLEN-1:0];
         RV32M_FUNC3_MULH,
         RV32M_FUNC3_MULHSU,
         RV32M_FUNC3_MULHU:                   fix_out = fix_prod[PROD_W-1:XLEN];
         RV32M_FUNC3_DIV,  RV32M_FUNC3_DIVU:  fix_out = fix_quot;
         default:                             fix_out = fix_rem;
      endcase
   end

   // Next-state and output logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      func3_d = func3_q;
      opnd_d  = opnd_q;
      acc_d   = acc_q;
      neg_a_d = neg_a_q;
      neg_b_d = neg_b_q;
      nofix_d = nofix_q;
      out_d   = out_q;
      done_d  = 1'b0;

      case (state_q)
         MULDIV_STATE_IDLE: begin
            if (req_i) begin
               func3_d = func3_i;
               neg_a_d = cond.neg_a;
               neg_b_d = cond.neg_b;
               nofix_d = 1'b0;
               cnt_d   = '0;
               if (!func3_i[2]) begin
`ifdef RV32M_FAST_MUL_EN
                  acc_d   = fast_prod;
                  nofix_d = 1'b1;
                  state_d = MULDIV_STATE_FIX;
`else
                  opnd_d  = cond.abs_a;
                  acc_d   = {{XLEN{1'b0}}, cond.abs_b};
                  state_d = MULDIV_STATE_MUL;
`endif
               end else if (div_by_zero) begin
                  acc_d   = {in0_i, {XLEN{1'b1}}};
                  nofix_d = 1'b1;
                  state_d = MULDIV_STATE_FIX;
               end else if (div_overflow) begin
                  acc_d   = {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
                  nofix_d = 1'b1;
                  state_d = MULDIV_STATE_FIX;
               end else begin
                  opnd_d  = cond.abs_b;
                  acc_d   = {{XLEN{1'b0}}, cond.abs_a};
                  state_d = MULDIV_STATE_DIV;
               end
            end
         end
         MULDIV_STATE_MUL: begin
            acc_d = mul_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(XLEN-1)) begin
               cnt_d   = '0;
               state_d = MULDIV_STATE_FIX;
            end
         end
         MULDIV_STATE_DIV: begin
            acc_d = div_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(XLEN-1)) begin
               cnt_d   = '0;
               state_d = MULDIV_STATE_FIX;
            end
         end
         default: begin
            out_d   = fix_out;
            done_d  = 1'b1;
            state_d = MULDIV_STATE_IDLE;
         end
      endcase

      // Flush wins over accept and over completion; result stays untouched.
      if (flush_i) begin
         state_d = MULDIV_STATE_IDLE;
         cnt_d   = '0;
         done_d  = 1'b0;
         out_d   = out_q;
      end
   end

   assign busy_d = (state_d != MULDIV_STATE_IDLE);

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= MULDIV_STATE_IDLE;
         cnt_q   <= '0;
         func3_q <= '0;
         opnd_q  <= '0;
         acc_q   <= '0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         nofix_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         func3_q <= func3_d;
         opnd_q  <= opnd_d;
         acc_q   <= acc_d;
         neg_a_q <= neg_a_d;
         neg_b_q <= neg_b_d;
         nofix_q <= nofix_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         out_q   <= out_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign out_o  = out_q;

endmodule

// File: tb/tb_riscv_32m_muldiv_sequencer.sv
// Self-checking bench for riscv_32m_muldiv_sequencer.
// Reference results come from plain 64-bit arithmetic on the operands.
// Honours RV32M_FAST_MUL_EN for expected multiply latency.
module tb_riscv_32m_muldiv_sequencer;

   logic        clock_i;
   logic        reset_i;
   logic        req_i;
   logic [2:0]  func3_i;
   logic [31:0] in0_i;
   logic [31:0] in1_i;
   logic        flush_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] out_o;

   int checks = 0;
   int errors = 0;

   riscv_32m_muldiv_sequencer dut (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .req_i   (req_i),
      .func3_i (func3_i),
      .in0_i   (in0_i),
      .in1_i   (in1_i),
      .flush_i (flush_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .out_o   (out_o)
   );

   initial clock_i = 1'b0;
   always #5 clock_i = ~clock_i;

   task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Reference result from the architectural definition of each op.
   function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      logic            ovf;
      sa  = $signed(a);
      sb  = $signed(b);
      ua  = {32'b0, a};
      ub  = {32'b0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf)    return 32'h8000_0000;
            return 32'($signed(a) / $signed(b));
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf)    return 32'h0;
            return 32'($signed(a) % $signed(b));
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
      if (!f[2]) begin
`ifdef RV32M_FAST_MUL_EN
         return 1;
`else
         return 33;
`endif
      end
      if (b == 0) return 1;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Counts edges after the accept edge until done_o is seen (sampled at
   // negedge). Optionally pulses req_i once while busy to test it is ignored.
   task automatic wait_done(input bit pulse, output int n);
      n = 0;
      forever begin
         @(posedge clock_i);
         n++;
         @(negedge clock_i);
         if (done_o) break;
         if (n >= 100) begin
            n = -1;
            break;
         end
         if (pulse && n == 2) begin
            req_i   = 1'b1;
            func3_i = 3'($urandom_range(0, 7));
            in0_i   = $urandom;
            in1_i   = $urandom;
         end
         if (pulse && n == 3) req_i = 1'b0;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input bit pulse);
      int n;
      @(negedge clock_i);
      req_i   = 1'b1;
      func3_i = f;
      in0_i   = a;
      in1_i   = b;
      @(negedge clock_i);
      req_i = 1'b0;
      if (ref_latency(f, a, b) > 1) check32({tag, "_busy"}, 32'(busy_o), 32'd1);
      wait_done(pulse, n);
      check32({tag, "_lat"}, 32'(n), 32'(ref_latency(f, a, b) - 1) + 32'd1);
      check32({tag, "_out"}, out_o, ref_result(f, a, b));
      check32({tag, "_idle"}, 32'(busy_o), 32'd0);
   endtask

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         4: return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int n;
      int done_seen;
      logic [31:0] prev;

      reset_i = 1'b1;
      req_i   = 1'b0;
      flush_i = 1'b0;
      func3_i = '0;
      in0_i   = '0;
      in1_i   = '0;
      repeat (2) @(negedge clock_i);
      check32("rst_busy", 32'(busy_o), 32'd0);
      check32("rst_done", 32'(done_o), 32'd0);
      check32("rst_out", out_o, 32'd0);
      reset_i = 1'b0;

      // Directed cases.
      run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op("mul_m7x3", 3'd0, -32'd7, 32'd3, 1'b0);
      run_op("mulhsu_m1x2", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
      run_op("div_m7_2", 3'd4, -32'd7, 32'd2, 1'b0);
      run_op("rem_m7_2", 3'd6, -32'd7, 32'd2, 1'b0);
      run_op("divu_by0", 3'd5, 32'd100, 32'd0, 1'b0);
      run_op("rem_by0", 3'd6, 32'd100, 32'd0, 1'b0);
      run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op("mul_6x7", 3'd0, 32'd6, 32'd7, 1'b0);
      run_op("mulh_minsq", 3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
      run_op("ignored_req", 3'd7, 32'd1000, 32'd7, 1'b1);

      // Flush at E10 of a divide: no done, result held, idle next cycle.
      prev = out_o;
      @(negedge clock_i);
      req_i = 1'b1; func3_i = 3'd4; in0_i = 32'd12345; in1_i = 32'd17;
      @(negedge clock_i);
      req_i = 1'b0;
      repeat (9) @(negedge clock_i);
      flush_i = 1'b1;
      @(negedge clock_i);
      flush_i = 1'b0;
      check32("flush_busy", 32'(busy_o), 32'd0);
      check32("flush_done", 32'(done_o), 32'd0);
      check32("flush_out", out_o, prev);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock_i);
         if (done_o) done_seen++;
      end
      check32("flush_no_done", 32'(done_seen), 32'd0);
      run_op("after_flush", 3'd5, 32'd12345, 32'd17, 1'b0);

      // Back-to-back: req_i held high across done_o.
      @(negedge clock_i);
      req_i = 1'b1; func3_i = 3'd1; in0_i = 32'h1234_5678; in1_i = 32'hF000_0001;
      @(negedge clock_i);
      func3_i = 3'd7; in0_i = 32'd99; in1_i = 32'd10;
      wait_done(1'b0, n);
      check32("b2b1_lat", 32'(n), 32'(ref_latency(3'd1, 32'h1234_5678, 32'hF000_0001)));
      check32("b2b1_out", out_o, ref_result(3'd1, 32'h1234_5678, 32'hF000_0001));
      @(negedge clock_i);
      req_i = 1'b0;
      check32("b2b2_busy", 32'(busy_o), 32'd1);
      wait_done(1'b0, n);
      check32("b2b2_lat", 32'(n), 32'(ref_latency(3'd7, 32'd99, 32'd10)));
      check32("b2b2_out", out_o, ref_result(3'd7, 32'd99, 32'd10));

      // Randomized ops against the reference model.
      for (int i = 0; i < 60; i++) begin
         run_op("rand", 3'($urandom_range(0, 7)), rand_opnd(), rand_opnd(),
                1'($urandom_range(0, 1)));
      end

      // Reset mid-multiply clears outputs immediately.
      @(negedge clock_i);
      req_i = 1'b1; func3_i = 3'd0; in0_i = 32'd55; in1_i = 32'd66;
      @(negedge clock_i);
      req_i = 1'b0;
      repeat (4) @(negedge clock_i);
      reset_i = 1'b1;
      #1;
      check32("rst_mid_busy", 32'(busy_o), 32'd0);
      check32("rst_mid_done", 32'(done_o), 32'd0);
      check32("rst_mid_out", out_o, 32'd0);
      @(negedge clock_i);
      reset_i = 1'b0;
      run_op("after_rst", 3'd0, 32'd55, 32'd66, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
